// File: rtl/sqrt_job_sequencer.sv
// sqrt_job_sequencer
// Streams 8-bit operands through a small FIFO into an odd-subtraction
// square-root unit, one job at a time over its St/done handshake.
// Each returned root is range-checked, and the unit is guarded by a
// timeout. Operand, root and remainder are presented on a registered
// valid/ready output port.

module sqrt_job_sequencer #(
    parameter int DEPTH   = 4,   // operand FIFO entries, power of 2, 2..16
    parameter int TIMEOUT = 64   // St-to-done limit in cycles, >= 40
) (
    input  logic                     clk,
    input  logic                     rstN,
    // operand stream
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_data,
    // square-root unit handshake
    output logic                     sq_St,
    output logic [7:0]               sq_N,
    input  logic                     sq_done,
    input  logic [3:0]               sq_root,
    // result stream
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_n,
    output logic [3:0]               out_root,
    output logic [7:0]               out_rem,
    output logic                     out_err,
    // status
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CHECK,
        S_RELEASE
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;

    state_t        r_state;
    state_t        w_state_next;

    logic [7:0]    r_sq_n;
    logic          r_sq_st;
    logic [TW-1:0] r_timer;
    logic [3:0]    r_root;
    logic          r_tmo;

    logic          r_out_valid;
    logic [7:0]    r_out_n;
    logic [3:0]    r_out_root;
    logic [7:0]    r_out_rem;
    logic          r_out_err;

    // ------------------------------------------------------------------
    // Handshake qualifiers
    // ------------------------------------------------------------------
    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_timeout_hit;
    logic w_load;

    assign w_full  = (r_level == LW'(DEPTH));
    assign w_empty = (r_level == '0);
    assign w_push  = in_valid && !w_full;

    // A new job is only taken once the unit has dropped done, so the
    // previous job's done tail can never be mistaken for a new result.
    assign w_pop = (r_state == S_IDLE) && !w_empty && !sq_done;

    assign w_timeout_hit = (r_state == S_WAIT) && !sq_done &&
                           (r_timer == TW'(TIMEOUT - 1));

    // The output register can take a new result when it is empty or being
    // drained in this same cycle.
    assign w_load = (r_state == S_CHECK) && (!r_out_valid || out_ready);

    // ------------------------------------------------------------------
    // Range check arithmetic, all at 9 bits so (15+1)^2 = 256 fits
    // ------------------------------------------------------------------
    logic [8:0] w_r9;
    logic [8:0] w_r1;
    logic [8:0] w_n9;
    logic [8:0] w_sq;
    logic [8:0] w_sq1;
    logic [8:0] w_diff;
    logic [7:0] w_rem;
    logic       w_err;

    assign w_r9   = {5'd0, r_root};
    assign w_r1   = w_r9 + 9'd1;
    assign w_n9   = {1'b0, r_sq_n};
    assign w_sq   = w_r9 * w_r9;
    assign w_sq1  = w_r1 * w_r1;
    assign w_diff = w_n9 - w_sq;
    assign w_rem  = (w_sq <= w_n9) ? w_diff[7:0] : 8'd0;
    // After a timeout the error is already set; the root checks are moot.
    assign w_err  = r_tmo || (w_sq > w_n9) || (w_sq1 <= w_n9);

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------

    // Operand storage; contents need no reset since occupancy is tracked
    // separately and stale entries are never read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Job FSM
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode for the issue / wait / check / release cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (w_pop) w_state_next = S_ISSUE;
            S_ISSUE:   w_state_next = S_WAIT;
            S_WAIT:    if (sq_done || w_timeout_hit) w_state_next = S_CHECK;
            S_CHECK:   if (w_load) w_state_next = S_RELEASE;
            S_RELEASE: if (!sq_done) w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    // Job datapath: operand latch, start strobe, timer and root capture.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_sq_n  <= '0;
            r_sq_st <= 1'b0;
            r_timer <= '0;
            r_root  <= '0;
            r_tmo   <= 1'b0;
        end else begin
            if (w_pop) begin
                r_sq_n <= r_mem[r_rd_ptr];
            end

            // St rises leaving ISSUE and stays up through WAIT and any
            // CHECK stall; it drops when the result is handed off.
            if (r_state == S_ISSUE) begin
                r_sq_st <= 1'b1;
            end else if (w_load) begin
                r_sq_st <= 1'b0;
            end

            if (r_state == S_ISSUE) begin
                r_timer <= '0;
            end else if (r_state == S_WAIT) begin
                r_timer <= r_timer + TW'(1);
            end

            if (r_state == S_WAIT) begin
                if (sq_done) begin
                    r_root <= sq_root;
                    r_tmo  <= 1'b0;
                end else if (w_timeout_hit) begin
                    r_root <= '0;
                    r_tmo  <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Result output register
    // ------------------------------------------------------------------

    // Load on CHECK hand-off; hold while valid and not accepted.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_out_valid <= 1'b0;
            r_out_n     <= '0;
            r_out_root  <= '0;
            r_out_rem   <= '0;
            r_out_err   <= 1'b0;
        end else begin
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_n     <= r_sq_n;
                r_out_root  <= r_root;
                r_out_rem   <= w_rem;
                r_out_err   <= w_err;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready  = !w_full;
    assign sq_St     = r_sq_st;
    assign sq_N      = r_sq_n;
    assign out_valid = r_out_valid;
    assign out_n     = r_out_n;
    assign out_root  = r_out_root;
    assign out_rem   = r_out_rem;
    assign out_err   = r_out_err;
    assign busy      = (r_state != S_IDLE) || !w_empty;
    assign level     = r_level;

endmodule

// File: tb/tb_sqrt_job_sequencer.sv
// Testbench for sqrt_job_sequencer: behavioural square-root unit model,
// scoreboard of expected results, directed scenarios plus a random phase.
`timescale 1ns/1ps

module tb_sqrt_job_sequencer;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;

    logic       clk = 1'b0;
    logic       rstN;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       sq_St;
    logic [7:0] sq_N;
    logic       sq_done;
    logic [3:0] sq_root;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_n;
    logic [3:0] out_root;
    logic [7:0] out_rem;
    logic       out_err;
    logic       busy;
    logic [$clog2(DEPTH):0] level;

    sqrt_job_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rstN      (rstN),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .sq_St     (sq_St),
        .sq_N      (sq_N),
        .sq_done   (sq_done),
        .sq_root   (sq_root),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_n     (out_n),
        .out_root  (out_root),
        .out_rem   (out_rem),
        .out_err   (out_err),
        .busy      (busy),
        .level     (level)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n;
        int root;
        int rem;
        int err;
    } res_t;

    res_t exp_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int rx_cnt      = 0;
    int viol        = 0;
    int last_st_len = 0;

    // unit model behaviour knobs
    bit hang      = 1'b0;
    bit bad       = 1'b0;
    int bad_val   = 0;
    int tail_len  = 1;
    int ready_mode = 1;   // 0 low, 1 high, 2 random

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Largest r with r*r <= n.
    function automatic int isqrt(input int n);
        int r = 0;
        while ((r + 1) * (r + 1) <= n) r++;
        return r;
    endfunction

    function automatic res_t expect_for(input int n);
        res_t e;
        e.n = n;
        if (hang) begin
            e.root = 0; e.rem = n; e.err = 1;
        end else if (bad) begin
            e.root = bad_val;
            e.rem  = (bad_val * bad_val <= n) ? n - bad_val * bad_val : 0;
            e.err  = (isqrt(n) != bad_val) ? 1 : 0;
        end else begin
            e.root = isqrt(n); e.rem = n - e.root * e.root; e.err = 0;
        end
        return e;
    endfunction

    // Behavioural square-root unit: done after a random latency while St
    // is high, held for tail_len cycles after St falls.
    initial begin
        int phase  = 0;
        int cnt    = 0;
        int lat    = 0;
        int tcnt   = 0;
        int st_run = 0;
        int nh     = 0;
        sq_done = 1'b0;
        sq_root = 4'd0;
        forever begin
            @(negedge clk);
            if (sq_St) st_run++;
            else if (st_run > 0) begin last_st_len = st_run; st_run = 0; end
            if (!rstN) begin
                phase = 0; sq_done = 1'b0; st_run = 0;
            end else begin
                case (phase)
                    0: if (sq_St) begin
                           nh = sq_N; cnt = 0; lat = $urandom_range(1, 30); phase = 1;
                       end
                    1: if (!sq_St) phase = 0;
                       else begin
                           if (sq_N != 8'(nh)) viol++;
                           cnt++;
                           if (!hang && cnt >= lat) begin
                               sq_done = 1'b1;
                               sq_root = 4'(bad ? bad_val : isqrt(nh));
                               phase = 2;
                           end
                       end
                    2: if (!sq_St) begin tcnt = tail_len; phase = 3; end
                    default: begin
                        if (sq_St) viol++;
                        tcnt--;
                        if (tcnt <= 0) begin sq_done = 1'b0; phase = 0; end
                    end
                endcase
            end
        end
    end

    // Consumer ready driver.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Result monitor / scoreboard.
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            if (rstN && out_valid && out_ready) begin
                check("result_expected", (exp_q.size() > 0) ? 1 : 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("out_n",    out_n,    e.n);
                    check("out_root", out_root, e.root);
                    check("out_rem",  out_rem,  e.rem);
                    check("out_err",  out_err,  e.err);
                    $display("result n=%0d root=%0d rem=%0d err=%0d", out_n, out_root, out_rem, out_err);
                end
                rx_cnt++;
            end
        end
    end

    // Offer one operand; returns one cycle after acceptance.
    task automatic push(input int v);
        int b = 0;
        bit got = 1'b0;
        in_valid = 1'b1;
        in_data  = v[7:0];
        while (!got && b < 300) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
            b++;
        end
        check("push_accepted", got, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (got) exp_q.push_back(expect_for(v));
    endtask

    task automatic wait_rx(input string tag, input int target, input int budget);
        int b = 0;
        while (rx_cnt < target && b < budget) begin
            @(negedge clk);
            b++;
        end
        check(tag, rx_cnt, target);
        @(posedge clk); #1;
    endtask

    task automatic check_idle_outputs(input string phase_tag);
        check({phase_tag, "_in_ready"},  in_ready,  1);
        check({phase_tag, "_sq_St"},     sq_St,     0);
        check({phase_tag, "_sq_N"},      sq_N,      0);
        check({phase_tag, "_out_valid"}, out_valid, 0);
        check({phase_tag, "_out_n"},     out_n,     0);
        check({phase_tag, "_out_root"},  out_root,  0);
        check({phase_tag, "_out_rem"},   out_rem,   0);
        check({phase_tag, "_out_err"},   out_err,   0);
        check({phase_tag, "_busy"},      busy,      0);
        check({phase_tag, "_level"},     level,     0);
    endtask

    initial begin
        int target;
        int bnd[5] = '{0, 1, 255, 225, 224};
        int waited;

        rstN = 1'b0;
        in_valid = 1'b0;
        in_data = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rstN = 1'b1;
        @(posedge clk); #1;

        // Single job
        ready_mode = 1;
        target = rx_cnt + 1;
        push(200);
        wait_rx("single_rx", target, 200);
        check("single_valid_one_cycle", out_valid, 0);

        // Boundary operands, in order
        target = rx_cnt + 5;
        foreach (bnd[i]) push(bnd[i]);
        wait_rx("boundary_rx", target, 600);

        // Backpressure: output stalled, FIFO fills
        ready_mode = 0;
        @(posedge clk); #1;
        target = rx_cnt + 6;
        for (int i = 0; i < 6; i++) push($urandom_range(0, 255));
        repeat (120) @(posedge clk);
        #1;
        check("bp_level_full",  level,     DEPTH);
        check("bp_in_ready",    in_ready,  0);
        check("bp_st_held",     sq_St,     1);
        check("bp_out_valid",   out_valid, 1);
        check("bp_busy",        busy,      1);
        check("bp_out_n_held",  out_n,     exp_q[0].n);
        ready_mode = 1;
        wait_rx("bp_rx", target, 1000);

        // Timeout, then a normal job
        hang = 1'b1;
        target = rx_cnt + 1;
        push(50);
        wait_rx("tmo_rx", target, 300);
        check("tmo_st_len", last_st_len, TIMEOUT + 1);
        hang = 1'b0;
        target = rx_cnt + 1;
        push($urandom_range(0, 255));
        wait_rx("post_tmo_rx", target, 200);

        // Long done tail: next St must wait for done to drop
        tail_len = 3;
        target = rx_cnt + 2;
        push($urandom_range(0, 255));
        push($urandom_range(0, 255));
        wait_rx("tail_rx", target, 300);
        check("tail_no_overlap", viol, 0);
        tail_len = 1;

        // Bad root from the unit
        bad = 1'b1;
        bad_val = 8;
        target = rx_cnt + 1;
        push(40);
        wait_rx("bad_rx", target, 200);
        bad = 1'b0;

        // Reset in the middle of a hung job with FIFO occupied
        hang = 1'b1;
        push($urandom_range(0, 255));
        waited = 0;
        while (!sq_St && waited < 20) begin @(negedge clk); waited++; end
        check("rst_st_seen", sq_St, 1);
        @(posedge clk); #1;
        push($urandom_range(0, 255));
        push($urandom_range(0, 255));
        check("rst_pre_level", level, 2);
        rstN = 1'b0;
        #1;
        check_idle_outputs("midrst");
        exp_q.delete();
        @(posedge clk); #1;
        hang = 1'b0;
        rstN = 1'b1;
        target = rx_cnt + 1;
        push(144);
        wait_rx("post_rst_rx", target, 200);
        repeat (20) @(posedge clk);
        #1;
        check("post_rst_rx_exact", rx_cnt, target);

        // Random traffic with random consumer readiness
        ready_mode = 2;
        target = rx_cnt + 24;
        for (int i = 0; i < 24; i++) push($urandom_range(0, 255));
        wait_rx("random_rx", target, 4000);
        ready_mode = 1;

        check("queue_drained", exp_q.size(), 0);
        check("unit_protocol", viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sqrt_job_sequencer.md
Name: sqrt_job_sequencer

Overview:
Upstream/downstream wrapper for the 8-bit odd-subtraction square-root unit. It accepts operands on a valid/ready stream into a small FIFO and issues them one at a time over the unit's St/done handshake. It captures each root, range-checks it, and presents operand, root and remainder on a registered valid/ready output. It also guards the unit with a timeout.

Parameters:
DEPTH, 4, operand FIFO entries; power of 2, 2..16.
TIMEOUT, 64, max cycles from St assertion to done before abort; must be >= 40, the worst-case unit latency.

Ports:
clk  input  1  clock, rising edge
rstN  input  1  reset, asynchronous, active-low
in_valid  input  1  operand offered
in_ready  output  1  FIFO not full
in_data  input  8  operand N
sq_St  output  1  start to sqrt unit, held until release
sq_N  output  8  operand to sqrt unit, stable while sq_St=1
sq_done  input  1  done from sqrt unit
sq_root  input  4  root from sqrt unit
out_valid  output  1  result held
out_ready  input  1  consumer accepts
out_n  output  8  operand of the result
out_root  output  4  captured root; 0 on timeout
out_rem  output  8  out_n - out_root^2, saturating at 0
out_err  output  1  timeout or range-check failure
busy  output  1  FSM not in IDLE, or FIFO not empty
level  output  clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset: all regs 0. in_ready=1, sq_St=0, sq_N=0, out_valid=0, out_n/out_root/out_rem/out_err=0, busy=0, level=0, FSM=IDLE. Asserting reset mid-job aborts silently and discards FIFO contents.
- FIFO: write on in_valid&in_ready. Pop occurs only on the IDLE->ISSUE transition. Simultaneous push and pop when full is not allowed (in_ready=0). Simultaneous push and pop when non-full leaves level unchanged. Pointers wrap mod DEPTH.
- FSM states:
  - IDLE: if FIFO non-empty and sq_done=0, pop the head into sq_N -> ISSUE.
  - ISSUE: sq_St=1, clear timer -> WAIT.
  - WAIT: sq_St=1, timer++.
    - If sq_done=1, capture sq_root -> CHECK.
    - Else if timer==TIMEOUT-1, set pending err, root=0 -> CHECK.
  - CHECK: compute rem=N-r^2. err|=(r^2>N)|((r+1)^2<=N) unless timeout. If out_valid=0 or out_ready=1 in this cycle, load the output regs -> RELEASE; else stay (stall, sq_St held 1).
  - RELEASE: sq_St=0. Wait until sq_done=0 (the unit keeps done high one cycle after St falls) -> IDLE.
- After a timeout, RELEASE waits for done=0 as usual. No next job is issued while sq_done=1.
- Output: out_valid set when CHECK loads and cleared on out_valid&out_ready. A same-cycle load and accept keeps out_valid=1 with the new data. Data is stable while out_valid&!out_ready.
- Arithmetic: r^2 and (r+1)^2 are computed at 9 bits unsigned. out_rem=N-r^2 when r^2<=N, else 0.
- Issue latency: 2 cycles from head available (IDLE) to sq_St=1. Results are returned in input order, at most one job in flight.
- busy = (state!=IDLE) | (level!=0).

Test Plan:
1. Single job: push N=200 with out_ready=1 -> sq_St pulse wraps unit run; out_root=14, out_rem=4, out_err=0, out_valid for 1 cycle.
2. Boundaries: push 0, 1, 255, 225, 224 -> roots 0, 1, 15, 15, 14; rems 0, 0, 30, 0, 28, in order.
3. Backpressure: out_ready=0, push 6 operands with DEPTH=4 -> in_ready drops when level=4 and the FSM stalls in CHECK. Release out_ready -> all results arrive in order, none lost or duplicated.
4. Timeout: model holds sq_done=0, push N=50 -> after 64 cycles out_err=1, out_root=0, out_rem=50. The next job proceeds normally.
5. Done tail: model keeps done=1 for 3 cycles after St falls -> the next sq_St is not asserted until done=0.
6. Bad root: model returns root 8 for N=40 -> out_err=1, out_rem=0. Then assert rstN mid-WAIT -> all outputs 0, level=0.
